mfcc_framing_frontend: RTL and testbench

//  MFCC front end. Chain: pre-emphasis filter -> PCM FIFO -> circular frame (window) buffer.

---
 rtl/mfcc_framing_frontend_if.sv | 28 ++
 rtl/mfcc_framing_frontend.sv | 178 +++++++++++++++++
 tb/tb_mfcc_framing_frontend.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_framing_frontend_if.sv
// Streaming/frame-read bus of the MFCC framing front end.
// The master side is the PCM source plus the window-stage consumer; the slave side is the front end.
interface mfcc_framing_frontend_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 400
);
  localparam int ADDR_W = $clog2(FRAME_SIZE);

  logic                           pcm_valid_i;
  logic signed [SAMPLE_WIDTH-1:0] pcm_i;
  logic                           pcm_full_o;
  logic                           start_move_i;
  logic                           rd_en_i;
  logic        [ADDR_W-1:0]       rd_addr_i;
  logic signed [SAMPLE_WIDTH-1:0] read_data_o;
  logic                           valid_to_read_o;
  logic                           frame_ready_o;

  modport master (
    output pcm_valid_i, pcm_i, start_move_i, rd_en_i, rd_addr_i,
    input  pcm_full_o, read_data_o, valid_to_read_o, frame_ready_o
  );

  modport slave (
    input  pcm_valid_i, pcm_i, start_move_i, rd_en_i, rd_addr_i,
    output pcm_full_o, read_data_o, valid_to_read_o, frame_ready_o
  );
endinterface

// File: rtl/mfcc_framing_frontend.sv
// MFCC framing front end: pre-emphasis -> first-word-fall-through PCM FIFO ->
// circular frame buffer that holds a FRAME_SIZE window and hops by MOVE_SIZE.
module mfcc_framing_frontend #(
  parameter int          SAMPLE_WIDTH = 16,
  parameter int unsigned ALPHA        = 31785,
  parameter int          FIFO_DEPTH   = 256,
  parameter int          FRAME_SIZE   = 400,
  parameter int          MOVE_SIZE    = 160
) (
  input logic                    clk,
  input logic                    rst_n,
  mfcc_framing_frontend_if.slave bus
);

  localparam int PW     = 2 * SAMPLE_WIDTH;
  localparam int DW     = SAMPLE_WIDTH + 2;
  localparam int FRAC   = SAMPLE_WIDTH - 1;
  localparam int FA     = $clog2(FIFO_DEPTH);
  localparam int AW     = $clog2(FRAME_SIZE);
  localparam int CW     = $clog2(FRAME_SIZE + 1);

  localparam logic signed [DW-1:0] SAT_MAX = DW'((1 <<< (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = DW'(-(1 <<< (SAMPLE_WIDTH - 1)));

  typedef enum logic {
    READY = 1'b0,
    FILL  = 1'b1
  } win_state_t;

  // ---------------------------------------------------------------- pre-emphasis
  logic signed [SAMPLE_WIDTH-1:0] x_prev;
  logic signed [SAMPLE_WIDTH-1:0] pre_y;
  logic                           pre_valid;
  logic signed [PW-1:0]           alpha_s;
  logic signed [PW-1:0]           prod;
  logic signed [PW-1:0]           scaled;
  logic signed [DW-1:0]           diff;
  logic signed [SAMPLE_WIDTH-1:0] sat_y;

  assign alpha_s = PW'(ALPHA);
  assign prod    = alpha_s * PW'(x_prev);
  assign scaled  = prod >>> FRAC;
  assign diff    = DW'(bus.pcm_i) - DW'(scaled);

  // Clamp the widened difference back into the signed sample range.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    sat_y = diff[SAMPLE_WIDTH-1:0];
    if (diff > SAT_MAX)      sat_y = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (diff < SAT_MIN) sat_y = SAT_MIN[SAMPLE_WIDTH-1:0];
  end

  // Register the filtered sample and remember the raw input for the next tap.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      x_prev    <= '0;
      pre_y     <= '0;
      pre_valid <= 1'b0;
    end else begin
      pre_valid <= bus.pcm_valid_i;
      if (bus.pcm_valid_i) begin
        pre_y  <= sat_y;
        x_prev <= bus.pcm_i;
      end
    end
  end

  // ---------------------------------------------------------------- PCM FIFO
  logic [SAMPLE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [FA-1:0]           fifo_wr_ptr;
  logic [FA-1:0]           fifo_rd_ptr;
  logic [FA:0]             fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [SAMPLE_WIDTH-1:0] fifo_data;
  win_state_t              state;

  assign fifo_empty     = (fifo_count == '0);
  assign fifo_full      = (fifo_count == (FA+1)'(FIFO_DEPTH));
  assign fifo_push      = pre_valid && !fifo_full;
  assign fifo_pop       = (state == FILL) && !fifo_empty;
  assign fifo_data      = fifo_mem[fifo_rd_ptr];
  // One slot of slack covers the sample already sitting in the pre-emphasis register.
  assign bus.pcm_full_o = (fifo_count >= (FA+1)'(FIFO_DEPTH - 1));

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; validity is tracked by the reset pointers and count.
    if (fifo_push) fifo_mem[fifo_wr_ptr] <= pre_y;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
      if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- frame buffer
  logic [SAMPLE_WIDTH-1:0] frame_mem [FRAME_SIZE];
  logic [AW-1:0]           write_ptr;
  logic [AW-1:0]           read_ptr;
  logic [CW-1:0]           remaining;
  logic [AW-1:0]           rd_idx;
  logic signed [SAMPLE_WIDTH-1:0] read_data_q;
  logic                    valid_q;
  logic                    frame_ready_q;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (AW+1)'(FRAME_SIZE)) s = s - (AW+1)'(FRAME_SIZE);
    return s[AW-1:0];
  endfunction

  assign rd_idx              = wrap_add(read_ptr, bus.rd_addr_i);
  assign bus.read_data_o     = read_data_q;
  assign bus.valid_to_read_o = valid_q;
  assign bus.frame_ready_o   = frame_ready_q;

  // Frame storage write port, fed straight from the FIFO head during FILL.
  always_ff @(posedge clk) begin
    if (fifo_pop) frame_mem[write_ptr] <= fifo_data;
  end

  // Window FSM: FILL loads samples until the frame is complete, READY serves reads and hops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      write_ptr     <= '0;
      read_ptr      <= '0;
      remaining     <= CW'(FRAME_SIZE);
      read_data_q   <= '0;
      valid_q       <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      frame_ready_q <= 1'b0;
      unique case (state)
        FILL: begin
          if (!fifo_empty) begin
            write_ptr <= wrap_add(write_ptr, AW'(1));
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
              state         <= READY;
              valid_q       <= 1'b1;
              frame_ready_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (bus.start_move_i) begin
            read_ptr  <= wrap_add(read_ptr, AW'(MOVE_SIZE));
            remaining <= CW'(MOVE_SIZE);
            state     <= FILL;
            valid_q   <= 1'b0;
          end else if (bus.rd_en_i) begin
            read_data_q <= frame_mem[rd_idx];
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_framing_frontend.sv
// Scoreboard bench for mfcc_framing_frontend: a randomized sine stream is pre-emphasized by a
// reference model; frame reads and hop pointers are queued as expectations and popped by monitors.
`timescale 1ns/1ps
module tb_mfcc_framing_frontend;
  localparam int FRAME_SIZE = 400;
  localparam int MOVE_SIZE  = 160;
  localparam int FIFO_DEPTH = 256;
  localparam int N_SAMPLES  = 1600;
  localparam int N_HOPS     = 6;

  typedef struct {
    int addr;
    int value;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mfcc_framing_frontend_if #(.SAMPLE_WIDTH(16), .FRAME_SIZE(FRAME_SIZE)) bus ();

  mfcc_framing_frontend #(
    .SAMPLE_WIDTH(16), .ALPHA(31785), .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_SIZE(FRAME_SIZE), .MOVE_SIZE(MOVE_SIZE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int x_in [N_SAMPLES];
  int emp  [N_SAMPLES];
  rd_exp_t exp_q [$];
  int ptr_q [$];
  int n_frames = 0;
  int n_sent   = 0;
  bit rd_pending = 1'b0;
  bit prev_fr    = 1'b0;
  bit prev_full  = 1'b0;
  bit saw_full   = 1'b0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Reference pre-emphasis: y = clamp(x - floor(0.97 * x_prev)) with 0.97 = 31785/32768.
  function automatic int pre_emph(input int x, input int xp);
    longint p, q, y;
    p = 64'(31785) * 64'(xp);
    if (p >= 0) q = p / 32768;
    else        q = -((-p + 32767) / 32768);
    y = 64'(x) - q;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  // Read monitor: one cycle after an accepted read, compare against the queued expectation.
  always @(posedge clk) rd_pending <= bus.rd_en_i && bus.valid_to_read_o && !bus.start_move_i;

  always @(negedge clk) begin
    if (rst_n && rd_pending) begin
      if (exp_q.size() == 0) check("read_unexpected", 0, 1);
      else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check($sformatf("frame_read@%0d", e.addr), bus.read_data_o, e.value);
      end
    end
  end

  // Frame-ready and backpressure monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_ready_o) begin
        n_frames++;
        check("ready_pulse_single", prev_fr, 0);
        check("ready_valid_high", bus.valid_to_read_o, 1);
        if (ptr_q.size() == 0) check("ready_unexpected", 0, 1);
        else check("ready_write_ptr", dut.write_ptr, ptr_q.pop_front());
      end
      if (bus.pcm_full_o && !prev_full) begin
        saw_full = 1'b1;
        check("full_assert_count", dut.fifo_count, FIFO_DEPTH - 1);
      end
      if (!bus.pcm_full_o && prev_full) check("full_release_count", dut.fifo_count, FIFO_DEPTH - 2);
      prev_fr   = bus.frame_ready_o;
      prev_full = bus.pcm_full_o;
    end else begin
      prev_fr   = 1'b0;
      prev_full = 1'b0;
    end
  end

  // Issue one frame read (caller is positioned just after a rising edge).
  task automatic do_read(input int addr, input int value);
    rd_exp_t e;
    e.addr = addr;
    e.value = value;
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = 9'(addr);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.rd_en_i = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!bus.valid_to_read_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, bus.valid_to_read_o, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},       bus.valid_to_read_o, 0);
    check({tag, "_frame_ready"}, bus.frame_ready_o, 0);
    check({tag, "_read_data"},   bus.read_data_o, 0);
    check({tag, "_pcm_full"},    bus.pcm_full_o, 0);
    check({tag, "_state_fill"},  dut.state, 1);
    check({tag, "_read_ptr"},    dut.read_ptr, 0);
    check({tag, "_write_ptr"},   dut.write_ptr, 0);
    check({tag, "_fifo_count"},  dut.fifo_count, 0);
    check({tag, "_remaining"},   dut.remaining, FRAME_SIZE);
  endtask

  task automatic driver();
    for (int i = 0; i < N_SAMPLES; i++) begin
      int budget = 20000;
      bit sent = 1'b0;
      while (!sent && budget > 0) begin
        @(posedge clk); #1;
        bus.pcm_valid_i = 1'b0;
        if (!bus.pcm_full_o && $urandom_range(0, 3) != 0) begin
          bus.pcm_valid_i = 1'b1;
          bus.pcm_i       = 16'(x_in[i]);
          sent = 1'b1;
        end
        budget--;
      end
      if (!sent) break;
      n_sent++;
    end
    @(posedge clk); #1;
    bus.pcm_valid_i = 1'b0;
    check("driver_sent_all", n_sent, N_SAMPLES);
  endtask

  task automatic consumer();
    int dir_exp [4];
    int last_read;
    dir_exp = '{1000, 30, 31797, -32768};
    ptr_q.push_back(0);
    wait_ready("first_frame_ready", 5000);
    check("first_read_ptr", dut.read_ptr, 0);
    for (int a = 0; a < FRAME_SIZE; a++) do_read(a, (a < 4) ? dir_exp[a] : emp[a]);
    begin
      int n = 0;
      while (!saw_full && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("pcm_full_seen", saw_full, 1);
    end
    for (int k = 1; k <= N_HOPS; k++) begin
      int base_old = (k - 1) * MOVE_SIZE;
      int base     = k * MOVE_SIZE;
      int exp_ptr  = base % FRAME_SIZE;
      do_read(0, emp[base_old]);
      last_read = emp[base_old];
      @(posedge clk); #1;
      bus.start_move_i = 1'b1;
      ptr_q.push_back(exp_ptr);
      @(posedge clk); #1;
      bus.start_move_i = 1'b0;
      check("hop_read_ptr", dut.read_ptr, exp_ptr);
      check("fill_valid_low", bus.valid_to_read_o, 0);
      bus.start_move_i = 1'b1;
      bus.rd_en_i      = 1'b1;
      bus.rd_addr_i    = 9'd7;
      @(posedge clk); #1;
      bus.start_move_i = 1'b0;
      bus.rd_en_i      = 1'b0;
      check("fill_ignore_read_ptr", dut.read_ptr, exp_ptr);
      check("fill_ignore_read_data", bus.read_data_o, last_read);
      wait_ready("hop_frame_ready", 5000);
      do_read(0, emp[base]);
      do_read(1, emp[base + 1]);
      do_read(MOVE_SIZE - 1, emp[base + MOVE_SIZE - 1]);
      do_read(FRAME_SIZE - MOVE_SIZE - 1, emp[base + FRAME_SIZE - MOVE_SIZE - 1]);
      do_read(FRAME_SIZE - MOVE_SIZE, emp[base + FRAME_SIZE - MOVE_SIZE]);
      do_read(FRAME_SIZE - 1, emp[base + FRAME_SIZE - 1]);
      for (int r = 0; r < 10; r++) begin
        int a = int'($urandom_range(0, FRAME_SIZE - 1));
        do_read(a, emp[base + a]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int xp;
    bus.pcm_valid_i  = 1'b0;
    bus.pcm_i        = '0;
    bus.start_move_i = 1'b0;
    bus.rd_en_i      = 1'b0;
    bus.rd_addr_i    = '0;

    for (int i = 0; i < N_SAMPLES; i++) begin
      real s;
      s = 16000.0 * $sin(2.0 * 3.14159265358979 * 440.0 * real'(i) / 16000.0);
      x_in[i] = $rtoi(s) + int'($urandom_range(0, 4000)) - 2000;
    end
    x_in[0] = 1000;   x_in[1] = 1000;
    x_in[2] = 32767;  x_in[3] = -32768;
    x_in[200] = 32767; x_in[201] = -32768;
    xp = 0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      emp[i] = pre_emph(x_in[i], xp);
      xp = x_in[i];
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Partial fill of 100 samples, then reset in the middle of FILL.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus.pcm_valid_i = 1'b1;
      bus.pcm_i       = 16'($urandom_range(0, 65535));
    end
    @(posedge clk); #1;
    bus.pcm_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midfill_remaining", dut.remaining, FRAME_SIZE - 100);
    rst_n = 1'b0;
    #1;
    check_reset_state("midfill_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    fork
      driver();
      consumer();
    join

    check("read_queue_drained", exp_q.size(), 0);
    check("ptr_queue_drained", ptr_q.size(), 0);
    check("frame_ready_count", n_frames, 1 + N_HOPS);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
